fetch_stage: RTL

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel. Memory returns in-order responses.
- Responses are buffered in a small FIFO and presented to decode as {instruction, pc} with a valid/ready handshake.
- Handles branch/jump redirects from execute by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/fetch_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage feeding decode. Owns the PC, issues word fetches
// over a valid/ready request channel, buffers in-order responses in a small
// FIFO and presents {instruction, pc} to decode with a valid/ready handshake.
// Taken branches/jumps from execute (redirect) flush the FIFO, restart fetch
// at the target and discard responses still in flight for stale requests.
//
// Optional feature (compile-time macro FETCH_MISALIGN_CHK_EN):
//   adds output misalign_err. A redirect to a non-word-aligned target sets
//   it (sticky) and blocks fetch until an aligned redirect or rst.
//   Without the macro the low two bits of redirect_pc are ignored.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   DEPTH     output FIFO entries and maximum requests in flight (pow2, >=2)
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   imem_req_valid     fetch request valid
//   imem_req_ready     memory accepts request this cycle
//   imem_req_addr      word-aligned fetch address (current PC)
//   imem_rsp_valid     in-order response valid
//   imem_rsp_data      fetched instruction word
//   redirect           one-cycle redirect pulse from execute
//   redirect_pc        redirect target
//   out_valid          instruction available to decode
//   out_ready          decode consumes this cycle
//   instruction        FIFO head instruction
//   pc                 PC of the FIFO head instruction
//   misalign_err       (macro only) sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counters each range 0..DEPTH inclusive.
    localparam int unsigned CW = $clog2(DEPTH + 1);
    // Sum of three counters needs two extra bits of headroom.
    localparam int unsigned SW = CW + 2;

    logic [31:0]   pc_reg;

    // PCs of accepted requests, in issue order, awaiting their response.
    logic [31:0]   inflight_pc [DEPTH];
    logic [AW-1:0] if_wr;
    logic [AW-1:0] if_rd;

    // Output FIFO storage.
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc    [DEPTH];
    logic [AW-1:0] buf_wr;
    logic [AW-1:0] buf_rd;

    logic [CW-1:0] occupancy;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    logic [SW-1:0] credits_used;
    logic          blocked;
    logic          req_fire;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          push;
    logic          pop;

    // -----------------------------------------------------------------------
    // Request side
    // -----------------------------------------------------------------------
    // Every FIFO slot is reserved at issue time: buffered entries, requests
    // in flight and responses still to be discarded all consume a credit,
    // so an accepted response always finds room in the FIFO.
    always_comb begin
        credits_used   = SW'(occupancy) + SW'(outstanding) + SW'(drop);
        imem_req_valid = !rst && !redirect && !blocked &&
                         (credits_used < SW'(DEPTH));
        imem_req_addr  = pc_reg;
        req_fire       = imem_req_valid && imem_req_ready;
    end

    // -----------------------------------------------------------------------
    // Response / output side
    // -----------------------------------------------------------------------
    always_comb begin
        rsp_keep    = imem_rsp_valid && (drop == '0);
        rsp_drop    = imem_rsp_valid && (drop != '0);
        out_valid   = (occupancy != '0);
        push        = rsp_keep && !redirect;
        pop         = out_valid && out_ready && !redirect;
        instruction = buf_instr[buf_rd];
        pc          = buf_pc[buf_rd];
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg      <= RESET_PC;
            if_wr       <= '0;
            if_rd       <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
            occupancy   <= '0;
            outstanding <= '0;
            drop        <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inflight_pc[i] <= '0;
                buf_instr[i]   <= '0;
                buf_pc[i]      <= '0;
            end
        end else if (redirect) begin
            pc_reg      <= {redirect_pc[31:2], 2'b00};
            if_wr       <= '0;
            if_rd       <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
            occupancy   <= '0;
            outstanding <= '0;
            // Everything still in flight becomes stale. Any drop left over
            // from an earlier redirect is carried forward so back-to-back
            // redirects keep counting every stale response exactly once;
            // a response arriving this cycle is already one of them.
            drop        <= drop + outstanding - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_reg             <= pc_reg + 32'd4;
                inflight_pc[if_wr] <= pc_reg;
                if_wr              <= if_wr + AW'(1);
            end
            if (rsp_keep) begin
                if_rd <= if_rd + AW'(1);
            end
            if (rsp_drop) begin
                drop <= drop - CW'(1);
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);

            if (push) begin
                buf_instr[buf_wr] <= imem_rsp_data;
                buf_pc[buf_wr]    <= inflight_pc[if_rd];
                buf_wr            <= buf_wr + AW'(1);
            end
            if (pop) begin
                buf_rd <= buf_rd + AW'(1);
            end
            occupancy <= occupancy + CW'(push) - CW'(pop);
        end
    end

    // -----------------------------------------------------------------------
    // Misaligned redirect detection
    // -----------------------------------------------------------------------
`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (redirect) begin
            misalign_err <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign blocked = misalign_err;
`else
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign blocked              = 1'b0;
`endif

endmodule
